// File: rtl/pipeline_ctrl.sv
// Pipeline enable/flush controller: arbitrates imem/dmem hits, issues the MEM-stage
// dmem request, holds early load data, tracks the sticky halt and cycle statistics.
module pipeline_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             branch_taken,
  input  logic             jump_mem,
  input  logic             halt_wb,
  input  logic [31:0]      dmemload_i,
  output logic             dREN_o,
  output logic             dWEN_o,
  output logic             iREN_o,
  output logic             pr_enable,
  output logic             pr_flush,
  output logic             pc_en,
  output logic [31:0]      dload_o,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DDONE = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic          mem_op;
  logic          ctrl_xfer;
  logic          pr_en;
  logic          flush;
  logic          dren;
  logic          dwen;
  logic          iren;
  logic          halt_ind;
  logic [DW-1:0] dload;

  assign mem_op    = mem_dREN | mem_dWEN;
  assign ctrl_xfer = branch_taken | jump_mem;

  // Next state, hold register, counters and raw (pre-reset-gating) outputs.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cyc_d    = cyc_q;
    stall_d  = stall_q;
    flush_d  = flush_q;
    pr_en    = 1'b0;
    dren     = 1'b0;
    dwen     = 1'b0;
    iren     = 1'b0;
    halt_ind = 1'b0;
    dload    = dmemload_i;

    case (state_q)
      RUN: begin
        dren  = mem_dREN;
        dwen  = mem_dWEN;
        iren  = 1'b1;
        pr_en = ihit & (!mem_op | dhit) & !halt_wb;
        if (halt_wb) begin
          state_d = HALT;
        end else if (mem_op && dhit && !ihit) begin
          // Access finished before the fetch: park so it is not re-issued.
          state_d = DDONE;
          if (mem_dREN) hold_d = dmemload_i;
        end
      end
      DDONE: begin
        iren  = 1'b1;
        pr_en = ihit & !halt_wb;
        dload = hold_q;
        if (halt_wb) begin
          state_d = HALT;
        end else if (ihit) begin
          state_d = RUN;
        end
      end
      HALT: begin
        halt_ind = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // A transfer held in a frozen MEM stage only flushes when the pipe advances.
    flush = ctrl_xfer & pr_en;

    if (state_q != HALT) begin
      cyc_d = cyc_q + CNT_W'(1);
      if (!pr_en) stall_d = stall_q + CNT_W'(1);
      if (flush)  flush_d = flush_q + CNT_W'(1);
    end
  end

  // State, load-data hold register and statistics counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      hold_q  <= '0;
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Outputs are forced quiet while reset is asserted.
  assign pr_enable   = nRST & pr_en;
  assign pc_en       = nRST & pr_en;
  assign pr_flush    = nRST & flush;
  assign dREN_o      = nRST & dren;
  assign dWEN_o      = nRST & dwen;
  assign iREN_o      = nRST & iren;
  assign halted      = nRST & halt_ind;
  assign dload_o     = nRST ? dload : '0;
  assign cyc_count   = cyc_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-cycle expectations go through a scoreboard queue.
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W = 32;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, mem_dREN, mem_dWEN, branch_taken, jump_mem, halt_wb;
  logic [31:0]      dmemload_i;
  logic             dREN_o, dWEN_o, iREN_o, pr_enable, pr_flush, pc_en, halted;
  logic [31:0]      dload_o;
  logic [CNT_W-1:0] cyc_count, stall_count, flush_count;

  typedef struct {
    logic        pe;
    logic        fl;
    logic        rd;
    logic        wr;
    logic        ir;
    logic        ht;
    logic [31:0] dl;
  } exp_t;

  exp_t sb_q[$];

  int chk_cnt = 0;
  int err_cnt = 0;
  int unsigned exp_cyc = 0, exp_stall = 0, exp_flush = 0;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .branch_taken(branch_taken), .jump_mem(jump_mem),
    .halt_wb(halt_wb), .dmemload_i(dmemload_i), .dREN_o(dREN_o), .dWEN_o(dWEN_o),
    .iREN_o(iREN_o), .pr_enable(pr_enable), .pr_flush(pr_flush), .pc_en(pc_en),
    .dload_o(dload_o), .halted(halted), .cyc_count(cyc_count),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, ".cyc"},   64'(cyc_count),   64'(exp_cyc));
    check_eq({tag, ".stall"}, 64'(stall_count), 64'(exp_stall));
    check_eq({tag, ".flush"}, 64'(flush_count), 64'(exp_flush));
  endtask

  // Drive one cycle of inputs, queue what must come out, then compare at the falling edge.
  task automatic step(input string tag,
                      input logic ih, dh, rd, wr, br, jm, hw, input logic [31:0] data,
                      input logic e_pe, e_fl, e_rd, e_wr, e_ir, e_ht, input logic [31:0] e_dl);
    exp_t e;
    exp_t o;
    ihit = ih; dhit = dh; mem_dREN = rd; mem_dWEN = wr;
    branch_taken = br; jump_mem = jm; halt_wb = hw; dmemload_i = data;
    e.pe = e_pe; e.fl = e_fl; e.rd = e_rd; e.wr = e_wr; e.ir = e_ir; e.ht = e_ht; e.dl = e_dl;
    sb_q.push_back(e);
    @(negedge CLK);
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      o = sb_q.pop_front();
      check_eq({tag, ".pr_enable"}, 64'(pr_enable), 64'(o.pe));
      check_eq({tag, ".pc_en"},     64'(pc_en),     64'(o.pe));
      check_eq({tag, ".pr_flush"},  64'(pr_flush),  64'(o.fl));
      check_eq({tag, ".dREN"},      64'(dREN_o),    64'(o.rd));
      check_eq({tag, ".dWEN"},      64'(dWEN_o),    64'(o.wr));
      check_eq({tag, ".iREN"},      64'(iREN_o),    64'(o.ir));
      check_eq({tag, ".halted"},    64'(halted),    64'(o.ht));
      if (!o.ht) check_eq({tag, ".dload"}, 64'(dload_o), 64'(o.dl));
      check_counts(tag);
      if (!o.ht) begin
        exp_cyc++;
        if (!o.pe) exp_stall++;
        if (o.fl)  exp_flush++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // Assert reset asynchronously with busy inputs, confirm everything is quiet, then release.
  task automatic do_reset(input string tag);
    ihit = 1'b1; dhit = 1'b1; mem_dREN = 1'b1; mem_dWEN = 1'b1;
    branch_taken = 1'b1; jump_mem = 1'b0; halt_wb = 1'b0; dmemload_i = 32'hCAFE_F00D;
    nRST = 1'b0;
    #1;
    exp_cyc = 0; exp_stall = 0; exp_flush = 0;
    check_eq({tag, ".rst_pr_enable"}, 64'(pr_enable), 64'd0);
    check_eq({tag, ".rst_pr_flush"},  64'(pr_flush),  64'd0);
    check_eq({tag, ".rst_pc_en"},     64'(pc_en),     64'd0);
    check_eq({tag, ".rst_dREN"},      64'(dREN_o),    64'd0);
    check_eq({tag, ".rst_dWEN"},      64'(dWEN_o),    64'd0);
    check_eq({tag, ".rst_iREN"},      64'(iREN_o),    64'd0);
    check_eq({tag, ".rst_halted"},    64'(halted),    64'd0);
    check_eq({tag, ".rst_dload"},     64'(dload_o),   64'd0);
    check_counts({tag, ".rst"});
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    nRST = 1'b0;
    ihit = 0; dhit = 0; mem_dREN = 0; mem_dWEN = 0;
    branch_taken = 0; jump_mem = 0; halt_wb = 0; dmemload_i = '0;
    @(posedge CLK);
    #1;

    // 1: ALU-only stream.
    do_reset("t1");
    for (int i = 0; i < 10; i++) begin
      d = $urandom();
      step("t1_alu", 1, 0, 0, 0, 0, 0, 0, d,  1, 0, 0, 0, 1, 0, d);
    end
    check_eq("t1_cyc10",  64'(cyc_count),   64'd10);
    check_eq("t1_stall0", 64'(stall_count), 64'd0);

    // 2: load with dhit and ihit together on cycle 3.
    do_reset("t2");
    step("t2_c1", 0, 0, 1, 0, 0, 0, 0, 32'hDEADBEEF,  0, 0, 1, 0, 1, 0, 32'hDEADBEEF);
    step("t2_c2", 0, 0, 1, 0, 0, 0, 0, 32'hDEADBEEF,  0, 0, 1, 0, 1, 0, 32'hDEADBEEF);
    step("t2_c3", 1, 1, 1, 0, 0, 0, 0, 32'hDEADBEEF,  1, 0, 1, 0, 1, 0, 32'hDEADBEEF);
    check_eq("t2_stall2", 64'(stall_count), 64'd2);
    step("t2_run", 1, 0, 0, 0, 0, 0, 0, 32'h0000_0042, 1, 0, 0, 0, 1, 0, 32'h0000_0042);

    // 3: dhit on cycle 2, ihit on cycle 5 -> DDONE holds the load data.
    do_reset("t3");
    step("t3_c1", 0, 0, 1, 0, 0, 0, 0, 32'h0,       0, 0, 1, 0, 1, 0, 32'h0);
    step("t3_c2", 0, 1, 1, 0, 0, 0, 0, 32'h1234,    0, 0, 1, 0, 1, 0, 32'h1234);
    step("t3_c3", 0, 0, 1, 0, 0, 0, 0, 32'hFFFF,    0, 0, 0, 0, 1, 0, 32'h1234);
    step("t3_c4", 0, 0, 1, 0, 0, 0, 0, 32'hFFFF,    0, 0, 0, 0, 1, 0, 32'h1234);
    step("t3_c5", 1, 0, 1, 0, 0, 0, 0, 32'hFFFF,    1, 0, 0, 0, 1, 0, 32'h1234);
    step("t3_c6", 1, 0, 0, 0, 0, 0, 0, 32'h55,      1, 0, 0, 0, 1, 0, 32'h55);
    check_eq("t3_stall4", 64'(stall_count), 64'd4);

    // 4: taken branch waits for a pending store, then a jump with no memory op.
    do_reset("t4");
    step("t4_c1", 1, 0, 0, 1, 1, 0, 0, 32'h1,  0, 0, 0, 1, 1, 0, 32'h1);
    step("t4_c2", 1, 0, 0, 1, 1, 0, 0, 32'h2,  0, 0, 0, 1, 1, 0, 32'h2);
    step("t4_c3", 1, 1, 0, 1, 1, 0, 0, 32'h3,  1, 1, 0, 1, 1, 0, 32'h3);
    check_eq("t4_flush1", 64'(flush_count), 64'd1);
    step("t4_jmp", 1, 0, 0, 0, 0, 1, 0, 32'h4, 1, 1, 0, 0, 1, 0, 32'h4);
    check_eq("t4_flush2", 64'(flush_count), 64'd2);
    check_eq("t4_stall2", 64'(stall_count), 64'd2);

    // 5: halt wins over dhit and a control transfer in the same cycle.
    do_reset("t5");
    step("t5_c1",  1, 0, 0, 0, 0, 0, 0, 32'h10,  1, 0, 0, 0, 1, 0, 32'h10);
    step("t5_hlt", 1, 1, 1, 0, 1, 0, 1, 32'h11,  0, 0, 1, 0, 1, 0, 32'h11);
    for (int i = 0; i < 3; i++) begin
      step("t5_frz", 1, 1, 1, 0, 1, 0, 1, 32'h12, 0, 0, 0, 0, 0, 1, 32'h12);
    end
    check_eq("t5_cyc2",   64'(cyc_count),   64'd2);
    check_eq("t5_stall1", 64'(stall_count), 64'd1);
    check_eq("t5_flush0", 64'(flush_count), 64'd0);

    // 6: reset while halted, then while in DDONE.
    do_reset("t6h");
    step("t6h_go", 1, 0, 0, 0, 0, 0, 0, 32'h20, 1, 0, 0, 0, 1, 0, 32'h20);
    step("t6_ld",  0, 1, 1, 0, 0, 0, 0, 32'hABCD, 0, 0, 1, 0, 1, 0, 32'hABCD);
    step("t6_dd",  0, 0, 1, 0, 0, 0, 0, 32'h9999, 0, 0, 0, 0, 1, 0, 32'hABCD);
    do_reset("t6d");
    step("t6d_go", 1, 0, 0, 0, 0, 0, 0, 32'h7,  1, 0, 0, 0, 1, 0, 32'h7);
    step("t6d_ld", 0, 0, 1, 0, 0, 0, 0, 32'h8,  0, 0, 1, 0, 1, 0, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
    $finish;
  end

endmodule
